// File: rtl/matrix_ops_pkg.sv
// Shared definitions for the matrix datapath blocks: FSM state type, index math for the
// row-major operand layout, and accumulator-to-output width conversion (wrap or clamp).
package matrix_ops_pkg;

    // Working width for the conversion helpers; accumulators and outputs must fit in it.
    localparam int CONV_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result = 0;
        int rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    function automatic int idx_width(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

    function automatic int elem_lsb(input int row, input int col, input int cols, input int width);
        return (row * cols + col) * width;
    endfunction

    function automatic int row_lsb(input int row, input int width);
        return row * width;
    endfunction

    function automatic logic [CONV_W-1:0] out_max(input int out_w, input bit is_signed);
        logic [CONV_W-1:0] mask;
        mask = (out_w >= CONV_W) ? {CONV_W{1'b1}} : ((CONV_W'(1) << out_w) - 1'b1);
        return is_signed ? (mask >> 1) : mask;
    endfunction

    function automatic logic [CONV_W-1:0] out_min(input int out_w, input bit is_signed);
        return is_signed ? ~out_max(out_w, 1'b1) : '0;
    endfunction

    // acc arrives already sign/zero-extended to CONV_W
    function automatic logic clamps(input logic [CONV_W-1:0] acc, input int out_w, input bit is_signed);
        if (is_signed)
            return ($signed(acc) > $signed(out_max(out_w, 1'b1))) ||
                   ($signed(acc) < $signed(out_min(out_w, 1'b1)));
        return acc > out_max(out_w, 1'b0);
    endfunction

    // Caller keeps the low out_w bits; without clamping that is a plain wrap.
    function automatic logic [CONV_W-1:0] convert(input logic [CONV_W-1:0] acc, input int out_w,
                                                  input bit is_signed, input bit sat_en);
        if (sat_en && clamps(acc, out_w, is_signed)) begin
            if (is_signed && acc[CONV_W-1])
                return out_min(out_w, is_signed);
            return out_max(out_w, is_signed);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: a single multiplier feeding an accumulator with clear
// and enable. o_acc_next exposes the sum including the current product.
module mac_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 18,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [ACC_WIDTH-1:0]  o_acc_next
);
    localparam int PROD_W = 2 * DATA_WIDTH;

    logic [PROD_W-1:0]    a_ext, b_ext, product;
    logic [ACC_WIDTH-1:0] product_ext, acc_reg;

    generate
        if (SIGNED != 0) begin : g_signed
            assign a_ext       = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
            assign b_ext       = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
            assign product_ext = ACC_WIDTH'($signed(product));
        end else begin : g_unsigned
            assign a_ext       = {{DATA_WIDTH{1'b0}}, i_a};
            assign b_ext       = {{DATA_WIDTH{1'b0}}, i_b};
            assign product_ext = ACC_WIDTH'(product);
        end
    endgenerate

    // The low PROD_W bits of the extended product are exact for both signednesses.
    assign product    = a_ext * b_ext;
    assign o_acc_next = acc_reg + product_ext;

    always_ff @(posedge clk) begin
        if (i_rst || i_clear)
            acc_reg <= '0;
        else if (i_en)
            acc_reg <= o_acc_next;
    end
endmodule

// File: rtl/matrix_vector_mac.sv
// Sequential matrix-by-vector dot-product engine with LANES parallel MAC lanes.
// Define MATRIX_VECTOR_MAC_SATURATE_EN to clamp narrowed results and add the o_sat port.
module matrix_vector_mac
    import matrix_ops_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 2,
    parameter int SIGNED     = 0,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH + clog2(COLS)
) (
    input  logic                            clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic                            i_abort,
    input  logic [ROWS*COLS*DATA_WIDTH-1:0] i_matrix,
    input  logic [COLS*DATA_WIDTH-1:0]      i_vector,
    output logic                            o_ready,
    output logic                            o_valid,
    output logic [ROWS*OUT_WIDTH-1:0]       o_result
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
    ,
    output logic [ROWS-1:0]                 o_sat
`endif
);
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + clog2(COLS);
    localparam int GROUPS    = ROWS / LANES;
    localparam int ROW_IW    = idx_width(ROWS);
    localparam int COL_IW    = idx_width(COLS);
    localparam int GRP_IW    = idx_width(GROUPS);
    localparam logic [COL_IW-1:0] COL_LAST = COL_IW'(COLS - 1);
    localparam logic [GRP_IW-1:0] GRP_LAST = GRP_IW'(GROUPS - 1);
    localparam bit IS_SIGNED = (SIGNED != 0);
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    generate
        if (ROWS % LANES != 0) begin : g_bad_lanes
            $error("matrix_vector_mac: ROWS must be divisible by LANES");
        end
        if (ACC_WIDTH > CONV_W || OUT_WIDTH > CONV_W) begin : g_bad_width
            $error("matrix_vector_mac: accumulator/output width exceeds conversion width");
        end
    endgenerate

    state_t                   state_reg, state_next;
    logic                     start_fire, done_fire, run_active, col_wrap, run_last;
    logic [COL_IW-1:0]        col_reg;
    logic [GRP_IW-1:0]        group_reg;
    logic [DATA_WIDTH-1:0]    mat_reg [ROWS][COLS];
    logic [DATA_WIDTH-1:0]    vec_reg [COLS];
    logic [ACC_WIDTH-1:0]     row_acc_reg [ROWS];
    logic [CONV_W-1:0]        acc_ext [ROWS];
    logic [ACC_WIDTH-1:0]     lane_acc_next [LANES];
    logic [ROW_IW-1:0]        lane_row [LANES];
    logic                     valid_reg;
    logic [ROWS*OUT_WIDTH-1:0] result_reg, result_next;

    assign run_active = (state_reg == RUN);
    assign col_wrap   = run_active && (col_reg == COL_LAST);
    assign run_last   = col_wrap && (group_reg == GRP_LAST);

    always_ff @(posedge clk) begin
        if (i_rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        start_fire = 1'b0;
        done_fire  = 1'b0;
        o_ready    = 1'b0;
        case (state_reg)
            IDLE: begin
                o_ready    = 1'b1;
                start_fire = i_start;
                if (i_start)
                    state_next = RUN;
            end
            RUN: begin
                if (i_abort)
                    state_next = IDLE;
                else if (run_last)
                    state_next = DONE;
            end
            DONE: begin
                done_fire  = !i_abort;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand snapshot: later input changes must not disturb a running operation.
    always_ff @(posedge clk) begin
        if (start_fire) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mat_reg[r][c] <= i_matrix[elem_lsb(r, c, COLS, DATA_WIDTH) +: DATA_WIDTH];
            for (int c = 0; c < COLS; c++)
                vec_reg[c] <= i_vector[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_row[gi] = ROW_IW'(int'(group_reg) * LANES + gi);
            mac_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH),
                .SIGNED     (SIGNED)
            ) u_lane (
                .clk        (clk),
                .i_rst      (i_rst),
                .i_clear    (start_fire || col_wrap),
                .i_en       (run_active),
                .i_a        (mat_reg[lane_row[gi]][col_reg]),
                .i_b        (vec_reg[col_reg]),
                .o_acc_next (lane_acc_next[gi])
            );
        end
        for (gi = 0; gi < ROWS; gi++) begin : g_ext
            if (IS_SIGNED) begin : g_s
                assign acc_ext[gi] = CONV_W'($signed(row_acc_reg[gi]));
            end else begin : g_u
                assign acc_ext[gi] = CONV_W'(row_acc_reg[gi]);
            end
        end
    endgenerate

    always_comb begin
        result_next = '0;
        for (int r = 0; r < ROWS; r++)
            result_next[row_lsb(r, OUT_WIDTH) +: OUT_WIDTH] =
                OUT_WIDTH'(convert(acc_ext[r], OUT_WIDTH, IS_SIGNED, SAT_EN));
    end

    // A lane finishes its row on the column wrap; the final product rides in via o_acc_next.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            col_reg    <= '0;
            group_reg  <= '0;
            valid_reg  <= 1'b0;
            result_reg <= '0;
            for (int r = 0; r < ROWS; r++)
                row_acc_reg[r] <= '0;
        end else begin
            valid_reg <= done_fire;
            if (start_fire) begin
                col_reg   <= '0;
                group_reg <= '0;
                for (int r = 0; r < ROWS; r++)
                    row_acc_reg[r] <= '0;
            end else if (run_active) begin
                if (col_wrap) begin
                    col_reg   <= '0;
                    group_reg <= (group_reg == GRP_LAST) ? '0 : group_reg + 1'b1;
                    for (int l = 0; l < LANES; l++)
                        row_acc_reg[lane_row[l]] <= lane_acc_next[l];
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
            if (done_fire)
                result_reg <= result_next;
        end
    end

    assign o_valid  = valid_reg;
    assign o_result = result_reg;

`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
    logic [ROWS-1:0] sat_reg, sat_next;

    always_comb begin
        sat_next = '0;
        for (int r = 0; r < ROWS; r++)
            sat_next[r] = clamps(acc_ext[r], OUT_WIDTH, IS_SIGNED);
    end

    always_ff @(posedge clk) begin
        if (i_rst || start_fire)
            sat_reg <= '0;
        else if (done_fire)
            sat_reg <= sat_next;
    end

    assign o_sat = sat_reg;
`endif
endmodule

// File: tb/tb_matrix_vector_mac.sv
// Directed testbench for matrix_vector_mac: five parameterisations driven from one
// sequence of scenario tasks with hand-computed expectations.
module tb_matrix_vector_mac;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]   rst_vec, start_vec, abort_vec;
    logic [127:0] matrix;
    logic [31:0]  vector;
    wire  [4:0]   ready_vec, valid_vec;
    wire  [71:0]  res0, res_sgn, res_l1, res_l4;
    wire  [63:0]  res_w16;
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
    wire  [3:0]   sat0, sat_w16, sat_sgn, sat_l1, sat_l4;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    localparam logic [71:0] EXP_ID   = {18'd4, 18'd3, 18'd2, 18'd1};
    localparam logic [71:0] EXP_RAMP = {18'd150, 18'd110, 18'd70, 18'd30};
    localparam logic [71:0] EXP_FULL = {4{18'd260100}};
    localparam logic [71:0] EXP_SGN  = {18'd0, 18'd0, 18'd0, 18'h3FE04};
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
    localparam logic [63:0] EXP_W16  = {4{16'd65535}};
`else
    localparam logic [63:0] EXP_W16  = {4{16'd63492}};
`endif

    matrix_vector_mac u_dut_def (
        .clk(clk), .i_rst(rst_vec[0]), .i_start(start_vec[0]), .i_abort(abort_vec[0]),
        .i_matrix(matrix), .i_vector(vector), .o_ready(ready_vec[0]), .o_valid(valid_vec[0]),
        .o_result(res0)
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
        , .o_sat(sat0)
`endif
    );
    matrix_vector_mac #(.OUT_WIDTH(16)) u_dut_w16 (
        .clk(clk), .i_rst(rst_vec[1]), .i_start(start_vec[1]), .i_abort(abort_vec[1]),
        .i_matrix(matrix), .i_vector(vector), .o_ready(ready_vec[1]), .o_valid(valid_vec[1]),
        .o_result(res_w16)
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
        , .o_sat(sat_w16)
`endif
    );
    matrix_vector_mac #(.SIGNED(1)) u_dut_sgn (
        .clk(clk), .i_rst(rst_vec[2]), .i_start(start_vec[2]), .i_abort(abort_vec[2]),
        .i_matrix(matrix), .i_vector(vector), .o_ready(ready_vec[2]), .o_valid(valid_vec[2]),
        .o_result(res_sgn)
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
        , .o_sat(sat_sgn)
`endif
    );
    matrix_vector_mac #(.LANES(1)) u_dut_l1 (
        .clk(clk), .i_rst(rst_vec[3]), .i_start(start_vec[3]), .i_abort(abort_vec[3]),
        .i_matrix(matrix), .i_vector(vector), .o_ready(ready_vec[3]), .o_valid(valid_vec[3]),
        .o_result(res_l1)
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
        , .o_sat(sat_l1)
`endif
    );
    matrix_vector_mac #(.LANES(4)) u_dut_l4 (
        .clk(clk), .i_rst(rst_vec[4]), .i_start(start_vec[4]), .i_abort(abort_vec[4]),
        .i_matrix(matrix), .i_vector(vector), .o_ready(ready_vec[4]), .o_valid(valid_vec[4]),
        .o_result(res_l4)
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
        , .o_sat(sat_l4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0: identity / v=1..4   1: all 255 / v all 255   2: row0 all -1 / v all 127   3: ramp 1..16 / v=1..4
    task automatic load(input int kind);
        logic [7:0] e;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                case (kind)
                    0:       e = (r == c) ? 8'd1 : 8'd0;
                    1:       e = 8'hFF;
                    2:       e = (r == 0) ? 8'hFF : 8'h00;
                    default: e = 8'(r * 4 + c + 1);
                endcase
                matrix[(r*4+c)*8 +: 8] = e;
            end
        end
        for (int c = 0; c < 4; c++)
            vector[c*8 +: 8] = (kind == 1) ? 8'hFF : (kind == 2) ? 8'd127 : 8'(c + 1);
    endtask

    task automatic pulse_start(input int idx);
        start_vec[idx] = 1'b1;
        tick();
        start_vec[idx] = 1'b0;
    endtask

    task automatic wait_valid(input int idx, input int limit, output int cycles);
        cycles = 0;
        while (!valid_vec[idx] && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    function automatic logic [71:0] res_of(input int idx);
        case (idx)
            0:       return res0;
            2:       return res_sgn;
            3:       return res_l1;
            default: return res_l4;
        endcase
    endfunction

    task automatic test_reset();
        rst_vec = '1;
        tick();
        tick();
        rst_vec = '0;
        for (int i = 0; i < 5; i++) begin
            n_compared++;
            if (ready_vec[i] !== 1'b1 || valid_vec[i] !== 1'b0) begin
                n_mismatched++;
                $display("FAIL reset_handshake dut%0d: ready=%b valid=%b, need ready=1 valid=0", i, ready_vec[i], valid_vec[i]);
            end
        end
        n_compared++;
        if (res0 !== 72'd0 || res_sgn !== 72'd0 || res_l1 !== 72'd0 || res_l4 !== 72'd0 || res_w16 !== 64'd0) begin
            n_mismatched++;
            $display("FAIL reset_result: def=%h sgn=%h l1=%h l4=%h w16=%h, need all zero", res0, res_sgn, res_l1, res_l4, res_w16);
        end
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
        n_compared++;
        if ({sat0, sat_w16, sat_sgn, sat_l1, sat_l4} !== 20'd0) begin
            n_mismatched++;
            $display("FAIL reset_sat: got %h, need 0", {sat0, sat_w16, sat_sgn, sat_l1, sat_l4});
        end
`endif
    endtask

    task automatic test_identity();
        int low_cycles = 0;
        load(0);
        pulse_start(0);
        for (int n = 0; n < 9; n++) begin
            if (!ready_vec[0] && !valid_vec[0])
                low_cycles++;
            tick();
        end
        $display("op identity dut0 result=%h", res0);
        n_compared++;
        if (low_cycles !== 9) begin
            n_mismatched++;
            $display("FAIL identity_busy_cycles: got %0d, need 9", low_cycles);
        end
        n_compared++;
        if (valid_vec[0] !== 1'b1 || ready_vec[0] !== 1'b1) begin
            n_mismatched++;
            $display("FAIL identity_valid_at_k9: valid=%b ready=%b, need 1 1", valid_vec[0], ready_vec[0]);
        end
        n_compared++;
        if (res0 !== EXP_ID) begin
            n_mismatched++;
            $display("FAIL identity_result: got %h, need %h", res0, EXP_ID);
        end
        tick();
        n_compared++;
        if (valid_vec[0] !== 1'b0 || res0 !== EXP_ID) begin
            n_mismatched++;
            $display("FAIL identity_pulse_hold: valid=%b result=%h, need 0 and %h", valid_vec[0], res0, EXP_ID);
        end
    endtask

    task automatic test_full_scale();
        int cycles;
        int extra_valid = 0;
        int extra_busy  = 0;
        load(1);
        pulse_start(0);
        wait_valid(0, 40, cycles);
        $display("op full_scale dut0 latency=%0d result=%h", cycles, res0);
        n_compared++;
        if (cycles !== 9 || res0 !== EXP_FULL) begin
            n_mismatched++;
            $display("FAIL full_scale: latency=%0d result=%h, need 9 and %h", cycles, res0, EXP_FULL);
        end
        tick();
        pulse_start(0);
        tick();
        tick();
        load(0);
        pulse_start(0);
        wait_valid(0, 40, cycles);
        $display("op start_ignored dut0 latency=%0d result=%h", cycles + 3, res0);
        n_compared++;
        if (cycles + 3 !== 9 || res0 !== EXP_FULL) begin
            n_mismatched++;
            $display("FAIL start_ignored: latency=%0d result=%h, need 9 and %h", cycles + 3, res0, EXP_FULL);
        end
        for (int n = 0; n < 15; n++) begin
            tick();
            if (valid_vec[0]) extra_valid++;
            if (!ready_vec[0]) extra_busy++;
        end
        n_compared++;
        if (extra_valid !== 0 || extra_busy !== 0) begin
            n_mismatched++;
            $display("FAIL start_not_queued: extra valid=%0d busy=%0d, need 0 0", extra_valid, extra_busy);
        end
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
        n_compared++;
        if (sat0 !== 4'b0000) begin
            n_mismatched++;
            $display("FAIL full_scale_sat: got %b, need 0000", sat0);
        end
`endif
    endtask

    task automatic test_narrow();
        int cycles;
        load(1);
        pulse_start(1);
        wait_valid(1, 40, cycles);
        $display("op narrow dut1 latency=%0d result=%h", cycles, res_w16);
        n_compared++;
        if (cycles !== 9 || res_w16 !== EXP_W16) begin
            n_mismatched++;
            $display("FAIL narrow_result: latency=%0d result=%h, need 9 and %h", cycles, res_w16, EXP_W16);
        end
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
        n_compared++;
        if (sat_w16 !== 4'b1111) begin
            n_mismatched++;
            $display("FAIL narrow_sat: got %b, need 1111", sat_w16);
        end
`endif
    endtask

    task automatic test_signed();
        int cycles;
        load(2);
        pulse_start(2);
        wait_valid(2, 40, cycles);
        $display("op signed dut2 latency=%0d result=%h", cycles, res_sgn);
        n_compared++;
        if (cycles !== 9 || res_sgn !== EXP_SGN) begin
            n_mismatched++;
            $display("FAIL signed_result: latency=%0d result=%h, need 9 and %h", cycles, res_sgn, EXP_SGN);
        end
    endtask

    task automatic test_abort();
        int cycles;
        int extra_valid = 0;
        load(0);
        pulse_start(0);
        wait_valid(0, 40, cycles);
        tick();
        load(1);
        pulse_start(0);
        tick();
        tick();
        tick();
        abort_vec[0] = 1'b1;
        tick();
        abort_vec[0] = 1'b0;
        $display("op abort dut0 result=%h", res0);
        n_compared++;
        if (ready_vec[0] !== 1'b1 || valid_vec[0] !== 1'b0 || res0 !== EXP_ID) begin
            n_mismatched++;
            $display("FAIL abort_state: ready=%b valid=%b result=%h, need 1 0 %h", ready_vec[0], valid_vec[0], res0, EXP_ID);
        end
        for (int n = 0; n < 12; n++) begin
            tick();
            if (valid_vec[0]) extra_valid++;
        end
        n_compared++;
        if (extra_valid !== 0 || res0 !== EXP_ID) begin
            n_mismatched++;
            $display("FAIL abort_no_output: valid pulses=%0d result=%h, need 0 and %h", extra_valid, res0, EXP_ID);
        end
        load(3);
        start_vec[0] = 1'b1;
        abort_vec[0] = 1'b1;
        tick();
        start_vec[0] = 1'b0;
        abort_vec[0] = 1'b0;
        n_compared++;
        if (ready_vec[0] !== 1'b0) begin
            n_mismatched++;
            $display("FAIL start_beats_abort: ready=%b, need 0", ready_vec[0]);
        end
        wait_valid(0, 40, cycles);
        $display("op start_with_abort dut0 latency=%0d result=%h", cycles, res0);
        n_compared++;
        if (cycles !== 9 || res0 !== EXP_RAMP) begin
            n_mismatched++;
            $display("FAIL start_beats_abort_result: latency=%0d result=%h, need 9 and %h", cycles, res0, EXP_RAMP);
        end
    endtask

    task automatic reset_and_rerun(input int idx, input int kind, input int lat, input logic [71:0] exp_res);
        int cycles;
        tick();
        load(kind);
        pulse_start(idx);
        tick();
        tick();
        rst_vec[idx] = 1'b1;
        tick();
        rst_vec[idx] = 1'b0;
        n_compared++;
        if (res_of(idx) !== 72'd0 || valid_vec[idx] !== 1'b0 || ready_vec[idx] !== 1'b1) begin
            n_mismatched++;
            $display("FAIL midrun_reset dut%0d: result=%h valid=%b ready=%b, need 0 0 1", idx, res_of(idx), valid_vec[idx], ready_vec[idx]);
        end
        pulse_start(idx);
        wait_valid(idx, 60, cycles);
        $display("op rerun dut%0d latency=%0d result=%h", idx, cycles, res_of(idx));
        n_compared++;
        if (cycles !== lat || res_of(idx) !== exp_res) begin
            n_mismatched++;
            $display("FAIL rerun dut%0d: latency=%0d result=%h, need %0d and %h", idx, cycles, res_of(idx), lat, exp_res);
        end
    endtask

    task automatic test_reset_mid_run();
        reset_and_rerun(0, 0, 9, EXP_ID);
        reset_and_rerun(3, 3, 17, EXP_RAMP);
        reset_and_rerun(4, 3, 5, EXP_RAMP);
    endtask

    initial begin
        rst_vec   = '1;
        start_vec = '0;
        abort_vec = '0;
        matrix    = '0;
        vector    = '0;
        test_reset();
        test_identity();
        test_full_scale();
        test_narrow();
        test_signed();
        test_abort();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
